serial_adder_ctrl: RTL and testbench

//   Bit-serial add/subtract sequencer built around a single 1-bit full-adder cell
//   (s = a^b^cin, c = maj(a,b,cin)). It latches two WIDTH-bit operands on a start

---
 rtl/serial_adder_ctrl_if.sv | 39 +++
 rtl/serial_adder_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_if
//   Request/result bundle between a requesting control unit (master) and the
//   bit-serial add/subtract sequencer (slave).
//
//   start  master->slave  request, honoured only while the sequencer is idle
//   sub    master->slave  0 = a+b+cin, 1 = a-b
//   a, b   master->slave  WIDTH-bit operands, captured together with start
//   cin    master->slave  carry-in for add (ignored for subtract)
//   busy   slave->master  high while an operation is in progress or completing
//   done   slave->master  one-cycle pulse, results valid from this cycle
//   sum    slave->master  WIDTH-bit result
//   cout   slave->master  carry-out (add) / no-borrow (subtract)
//   ovf    slave->master  signed overflow
// ---------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial add/subtract sequencer around a single 1-bit full-adder cell.
//   On start (in IDLE) it captures both operands, then steps the cell once per
//   clock, LSB first, with a registered carry. After WIDTH steps it publishes
//   sum, carry-out and signed overflow together with a one-cycle done pulse.
//   Subtraction is performed as a + ~b + 1.
//
//   clk    in   1       rising-edge clock
//   rst_n  in   1       synchronous reset, active-low; aborts any operation
//   bus    slave        request/result bundle (see serial_adder_ctrl_if)
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_ctrl_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MSB_CIN  = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_r_sr;
  logic             r_carry;
  logic             r_c_msb_in;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_cell_s;
  logic             w_cell_c;
  logic [WIDTH-1:0] w_r_next;

  // The shared 1-bit full-adder cell.
  assign w_cell_s = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_cell_c = (r_a_sr[0] & r_b_sr[0]) |
                    (r_a_sr[0] & r_carry)   |
                    (r_b_sr[0] & r_carry);

  // Result bits enter from the MSB side so that after WIDTH steps the LSB
  // computed first has reached bit 0.
  assign w_r_next = {w_cell_s, r_r_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_a_sr     <= '0;
      r_b_sr     <= '0;
      r_r_sr     <= '0;
      r_carry    <= 1'b0;
      r_c_msb_in <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_sr  <= bus.a;
            r_b_sr  <= bus.sub ? ~bus.b : bus.b;
            // Subtract needs the +1 of two's complement as the initial carry.
            r_carry <= bus.sub | bus.cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_r_sr  <= w_r_next;
          r_carry <= w_cell_c;
          r_cnt   <= r_cnt + 1'b1;
          // Carry produced by bit WIDTH-2 is the carry into the MSB.
          if (r_cnt == MSB_CIN) begin
            r_c_msb_in <= w_cell_c;
          end
          if (r_cnt == LAST_BIT) begin
            r_sum   <= w_r_next;
            r_cout  <= w_cell_c;
            r_ovf   <= r_c_msb_in ^ w_cell_c;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Self-checking bench for serial_adder_ctrl (WIDTH=8). Expected results come
//   from an arithmetic reference model (integer add/subtract with signed range
//   check for overflow).
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic s);
    int ua, ub, sa, sb, ures, sres;
    logic [W-1:0] r;
    logic co, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      ures = ua - ub;
      sres = sa - sb;
      co   = (ua >= ub);
    end else begin
      ures = ua + ub + int'(ci);
      sres = sa + sb + int'(ci);
      co   = (ures >= (1 << W));
    end
    r  = ures[W-1:0];
    ov = (sres > ((1 << (W-1)) - 1)) || (sres < -(1 << (W-1)));
    return {ov, co, r};
  endfunction

  // Runs one operation; optionally disturbs inputs after the start edge and
  // re-pulses start during SHIFT. Observes 20 cycles after the start edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic s, input bit disturb,
                       output logic [W-1:0] rs, output logic rc, output logic ro,
                       output int lat, output int busy_n, output int done_n);
    rs = 'x; rc = 1'bx; ro = 1'bx;
    lat = -1; busy_n = 0; done_n = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = ci; bus.sub = s;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (lat < 0) begin
          lat = k; rs = bus.sum; rc = bus.cout; ro = bus.ovf;
        end
      end
      if (k == 1) begin
        bus.start = 1'b0;
        if (disturb) begin
          bus.a = ~a; bus.b = W'($urandom); bus.cin = ~ci; bus.sub = ~s;
        end
      end
      if (disturb && k == 3) begin
        bus.start = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom);
      end
      if (disturb && k == 4) bus.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b sum=%h cout=%b ovf=%b required all 0",
               bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] a_t [5] = '{8'h5A, 8'hFF, 8'hFF, 8'h10, 8'h80};
    logic [W-1:0] b_t [5] = '{8'h33, 8'h01, 8'hFF, 8'h20, 8'h01};
    logic         c_t [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic         s_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W+1:0] e_t [5] = '{{1'b1, 1'b0, 8'h8D}, {1'b0, 1'b1, 8'h00},
                              {1'b0, 1'b1, 8'hFF}, {1'b0, 1'b0, 8'hF0},
                              {1'b1, 1'b1, 8'h7F}};
    logic [W-1:0] rs;
    logic rc, ro;
    int lat, bn, dn;
    for (int i = 0; i < 5; i++) begin
      do_op(a_t[i], b_t[i], c_t[i], s_t[i], 1'b0, rs, rc, ro, lat, bn, dn);
      checks++;
      if ({ro, rc, rs} !== e_t[i]) begin
        errors++;
        $display("FAIL directed_%0d result ovf/cout/sum=%b/%b/%h required %b/%b/%h",
                 i, ro, rc, rs, e_t[i][W+1], e_t[i][W], e_t[i][W-1:0]);
      end
      checks++;
      if (lat !== W + 1 || bn !== W + 1 || dn !== 1) begin
        errors++;
        $display("FAIL directed_%0d timing done_at=%0d busy_cycles=%0d dones=%0d required %0d %0d 1",
                 i, lat, bn, dn, W + 1, W + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, rs;
    logic ci, s, rc, ro;
    logic [W+1:0] exp_v;
    int lat, bn, dn;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom); b = W'($urandom);
      ci = 1'($urandom); s = 1'($urandom);
      exp_v = model(a, b, ci, s);
      do_op(a, b, ci, s, 1'b0, rs, rc, ro, lat, bn, dn);
      checks++;
      if ({ro, rc, rs} !== exp_v || lat !== W + 1 || dn !== 1) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h cin=%b sub=%b got %b/%b/%h lat=%0d dones=%0d required %b/%b/%h lat=%0d dones=1",
                 i, a, b, ci, s, ro, rc, rs, lat, dn,
                 exp_v[W+1], exp_v[W], exp_v[W-1:0], W + 1);
      end
    end
  endtask

  task automatic test_ignore_start_busy();
    logic [W-1:0] rs;
    logic rc, ro;
    logic [W+1:0] exp_v;
    int lat, bn, dn;
    exp_v = model(8'h3C, 8'h5B, 1'b1, 1'b0);
    do_op(8'h3C, 8'h5B, 1'b1, 1'b0, 1'b1, rs, rc, ro, lat, bn, dn);
    checks++;
    if ({ro, rc, rs} !== exp_v) begin
      errors++;
      $display("FAIL busy_start_result got %b/%b/%h required %b/%b/%h",
               ro, rc, rs, exp_v[W+1], exp_v[W], exp_v[W-1:0]);
    end
    checks++;
    if (dn !== 1 || bn !== W + 1) begin
      errors++;
      $display("FAIL busy_start_single dones=%0d busy_cycles=%0d required 1 %0d", dn, bn, W + 1);
    end
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] rs;
    logic rc, ro;
    int lat, bn, dn, seen;
    // Leave a nonzero published result first so the clear is visible.
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, rs, rc, ro, lat, bn, dn);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h77; bus.b = 8'h11; bus.cin = 1'b0; bus.sub = 1'b0;
    @(negedge clk);                 // cycle after start edge
    bus.start = 1'b0;
    repeat (3) @(negedge clk);      // reset sampled on the bit-3 shift edge
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== '0) begin
      errors++;
      $display("FAIL midop_reset busy=%b done=%b sum=%h cout=%b ovf=%b required all 0",
               bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
    end
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midop_no_done busy_or_done_cycles=%0d required 0", seen);
    end
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, rs, rc, ro, lat, bn, dn);
    checks++;
    if ({rc, rs} !== {1'b0, 8'h02} || dn !== 1) begin
      errors++;
      $display("FAIL midop_recover cout/sum=%b/%h dones=%0d required 0/02 1", rc, rs, dn);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a_q [3], b_q [3];
    logic c_q [3], s_q [3];
    logic [W+1:0] exp_v;
    int idx, t_last, cyc;
    for (int i = 0; i < 3; i++) begin
      a_q[i] = W'($urandom); b_q[i] = W'($urandom);
      c_q[i] = 1'($urandom); s_q[i] = 1'($urandom);
    end
    idx = 0; t_last = -1; cyc = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a_q[0]; bus.b = b_q[0]; bus.cin = c_q[0]; bus.sub = s_q[0];
    while (idx < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        exp_v = model(a_q[idx], b_q[idx], c_q[idx], s_q[idx]);
        checks++;
        if ({bus.ovf, bus.cout, bus.sum} !== exp_v) begin
          errors++;
          $display("FAIL b2b_result_%0d got %b/%b/%h required %b/%b/%h", idx,
                   bus.ovf, bus.cout, bus.sum, exp_v[W+1], exp_v[W], exp_v[W-1:0]);
        end
        if (t_last >= 0) begin
          checks++;
          if (cyc - t_last !== W + 2) begin
            errors++;
            $display("FAIL b2b_spacing_%0d got %0d required %0d", idx, cyc - t_last, W + 2);
          end
        end
        t_last = cyc;
        idx++;
        if (idx < 3) begin
          bus.a = a_q[idx]; bus.b = b_q[idx]; bus.cin = c_q[idx]; bus.sub = s_q[idx];
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (idx !== 3) begin
      errors++;
      $display("FAIL b2b_count dones=%0d required 3 within 60 cycles", idx);
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start_busy();
    test_reset_midop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
